// File: rtl/mem_arbiter_ctrl.sv
// Byte-wide RAM/IO bus controller: serialises icache line fills and LSB loads/stores
// into single-byte RAM cycles, assembling little-endian and pulsing a done per transfer.
module mem_arbiter_ctrl #(
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    if_en,
  input  logic [ADDR_W-1:0]       if_pc,
  output logic [8*LINE_BYTES-1:0] if_data,
  output logic                    if_done,
  input  logic                    lsb_en,
  input  logic                    lsb_wr,
  input  logic [ADDR_W-1:0]       lsb_addr,
  input  logic [1:0]              lsb_len,
  input  logic [31:0]             lsb_wdata,
  output logic [31:0]             lsb_rdata,
  output logic                    lsb_done,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  localparam int unsigned LINE_W = 8 * LINE_BYTES;
  localparam int unsigned CNT_W  = $clog2(LINE_BYTES + 1);

  typedef enum logic [1:0] {S_IDLE, S_IF, S_LOAD, S_STORE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, len_q, len_d, lsb_n_c;
  logic [ADDR_W-1:0] base_q, base_d, mem_a_d;
  logic [31:0]       wdata_q, wdata_d, lsb_rdata_d;
  logic [LINE_W-1:0] buf_q, buf_d, if_data_d;
  logic [7:0]        mem_dout_d;
  logic              if_done_d, lsb_done_d, mem_wr_q, mem_wr_d;
  logic              lsb_go_c, if_go_c, acc_stall_c, st_stall_c;

  // Acceptance qualifiers; a held request is ignored while its own done is still high
  assign lsb_go_c    = lsb_en && !lsb_done && (lsb_wr || !rollback);
  assign if_go_c     = if_en && !if_done;
  assign acc_stall_c = (lsb_addr[17:16] == 2'b11) && io_buffer_full;
  assign st_stall_c  = (base_q[17:16] == 2'b11) && io_buffer_full;
  assign lsb_n_c     = (lsb_len == 2'd2) ? CNT_W'(4) : CNT_W'(lsb_len) + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_data_d   = if_data;
    if_done_d   = 1'b0;
    lsb_rdata_d = lsb_rdata;
    lsb_done_d  = 1'b0;
    mem_a_d     = mem_a;
    mem_dout_d  = mem_dout;
    mem_wr_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (lsb_go_c) begin
          base_d  = lsb_addr;
          len_d   = lsb_n_c;
          wdata_d = lsb_wdata;
          buf_d   = '0;
          if (lsb_wr) begin
            state_d = S_STORE;
            cnt_d   = '0;
            if (!acc_stall_c) begin
              mem_a_d    = lsb_addr;
              mem_dout_d = lsb_wdata[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = CNT_W'(1);
            end
          end else begin
            state_d = S_LOAD;
            mem_a_d = lsb_addr;
            cnt_d   = CNT_W'(1);
          end
        end else if (if_go_c) begin
          state_d = S_IF;
          base_d  = if_pc;
          len_d   = CNT_W'(LINE_BYTES);
          buf_d   = '0;
          mem_a_d = if_pc;
          cnt_d   = CNT_W'(1);
        end
      end

      S_IF, S_LOAD: begin
        if (state_q == S_LOAD && rollback) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          mem_a_d = '0;
        end else begin
          // Byte cnt-1 is on mem_din for the address issued on the previous edge
          for (int unsigned i = 0; i < LINE_BYTES; i++) begin
            if (cnt_q == CNT_W'(i + 1)) buf_d[8*i +: 8] = mem_din;
          end
          if (cnt_q == len_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            mem_a_d = '0;
            if (state_q == S_IF) begin
              if_data_d = buf_d;
              if_done_d = 1'b1;
            end else begin
              lsb_rdata_d = buf_d[31:0];
              lsb_done_d  = 1'b1;
            end
          end else begin
            mem_a_d = base_q + ADDR_W'(cnt_q);
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      S_STORE: begin
        if (cnt_q == len_q) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          mem_a_d    = '0;
          lsb_done_d = 1'b1;
        end else if (!st_stall_c) begin
          mem_a_d    = base_q + ADDR_W'(cnt_q);
          mem_dout_d = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // rdy=0 freezes every register so the transfer resumes cycle-exact
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      buf_q     <= '0;
      if_data   <= '0;
      if_done   <= 1'b0;
      lsb_rdata <= '0;
      lsb_done  <= 1'b0;
      mem_a     <= '0;
      mem_dout  <= '0;
      mem_wr_q  <= 1'b0;
    end else if (rdy) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      buf_q     <= buf_d;
      if_data   <= if_data_d;
      if_done   <= if_done_d;
      lsb_rdata <= lsb_rdata_d;
      lsb_done  <= lsb_done_d;
      mem_a     <= mem_a_d;
      mem_dout  <= mem_dout_d;
      mem_wr_q  <= mem_wr_d;
    end
  end

  // A write held across an rdy stall must not be seen by the RAM more than once
  assign mem_wr = mem_wr_q & rdy;

endmodule
